// File: rtl/hist_bin_dispatcher.sv
// Histogram bin dispatcher: classifies tagged start/end events into a bin address around CENTER,
// queues in-range bins in a small FIFO and issues one req/ack increment per bin to histogram memory.
module hist_bin_dispatcher #(
    parameter int CH_W       = 2,
    parameter int INT_W      = 7,
    parameter int ADDR_W     = 8,
    parameter int CENTER     = 128,
    parameter int CH_A       = 1,
    parameter int CH_B       = 2,
    parameter int COINC_S    = 0,
    parameter int COINC_E    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          evt_valid,
    input  logic [CH_W-1:0]               evt_start,
    input  logic [CH_W-1:0]               evt_end,
    input  logic [INT_W-1:0]              evt_interval,
    input  logic                          fold_en,
    input  logic                          clr_stats,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              oor_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int SW    = ADDR_W + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam logic signed [SW-1:0] CENTER_S = SW'(CENTER);
    localparam logic [CH_W-1:0]      CODE_A   = CH_W'(CH_A);
    localparam logic [CH_W-1:0]      CODE_B   = CH_W'(CH_B);
    localparam logic [CH_W-1:0]      CODE_CS  = CH_W'(COINC_S);
    localparam logic [CH_W-1:0]      CODE_CE  = CH_W'(COINC_E);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // The two guard bits above ADDR_W are zero only for results inside [0, 2^ADDR_W-1].
    function automatic logic in_range(input logic signed [SW-1:0] b);
        return (b[SW-1:ADDR_W] == 2'b00);
    endfunction

    logic                    is_coinc;
    logic                    is_pos;
    logic                    is_neg;
    logic                    classed_p0;
    logic signed [SW-1:0]    intv_s;
    logic signed [SW-1:0]    bin_p0;
    logic                    vld_p0;
    logic                    oor_p0;

    logic [0:0]              state;
    logic [ADDR_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // ---- stage p0: combinational classification of the incoming event ----
    always_comb begin
        is_coinc   = 1'b0;
        is_pos     = 1'b0;
        is_neg     = 1'b0;
        intv_s     = signed'({{(SW-INT_W){1'b0}}, evt_interval});
        bin_p0     = CENTER_S;
        classed_p0 = 1'b0;
        vld_p0     = 1'b0;
        oor_p0     = 1'b0;

        is_coinc = (evt_start == CODE_CS) && (evt_end == CODE_CE) && (evt_interval == '0);
        is_pos   = (evt_start == CODE_A) && (evt_end == CODE_B);
        is_neg   = (evt_start == CODE_B) && (evt_end == CODE_A);

        if (is_coinc)
            bin_p0 = CENTER_S;
        else if (is_pos || (is_neg && fold_en))
            bin_p0 = CENTER_S + intv_s;
        else if (is_neg)
            bin_p0 = CENTER_S - intv_s;

        classed_p0 = evt_valid && (is_coinc || is_pos || is_neg);
        vld_p0     = classed_p0 && in_range(bin_p0);
        oor_p0     = classed_p0 && !in_range(bin_p0);
    end

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_REQ) && mem_ack));
    // A full FIFO still accepts a push when the dispatcher frees a slot on the same edge.
    assign push       = vld_p0 && (!fifo_full || pop);
    assign drop       = vld_p0 && !push;
    assign fifo_level = level;

    // ---- stage p1: FIFO storage and pointers ----
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bin_p0[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ---- stage p2: request FSM towards histogram memory ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        mem_addr <= fifo_mem[rd_ptr];
                        mem_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (pop) begin
                            mem_addr <= fifo_mem[rd_ptr];
                        end else begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            drop_cnt <= '0;
            oor_cnt  <= '0;
        end else if (clr_stats) begin
            hit_cnt  <= '0;
            drop_cnt <= '0;
            oor_cnt  <= '0;
        end else begin
            if (push)
                hit_cnt <= sat_inc(hit_cnt);
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
            if (oor_p0)
                oor_cnt <= sat_inc(oor_cnt);
        end
    end

endmodule

// File: tb/tb_hist_bin_dispatcher.sv
// Directed bench for hist_bin_dispatcher: default instance plus a CENTER=200, CNT_W=2 instance
// for out-of-range and counter saturation behaviour.
module tb_hist_bin_dispatcher;

    logic        clk;
    logic        rst_n;

    logic        evt_valid, fold_en, clr_stats, mem_ack, mem_req;
    logic [1:0]  evt_start, evt_end;
    logic [6:0]  evt_interval;
    logic [7:0]  mem_addr;
    logic [15:0] hit_cnt, drop_cnt, oor_cnt;
    logic [2:0]  fifo_level;

    logic        e2_valid, e2_fold, e2_clr, e2_ack, e2_req;
    logic [1:0]  e2_start, e2_end;
    logic [6:0]  e2_interval;
    logic [7:0]  e2_addr;
    logic [1:0]  e2_hit, e2_drop, e2_oor;
    logic [2:0]  e2_level;

    int checks = 0;
    int failures = 0;

    hist_bin_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_start(evt_start),
        .evt_end(evt_end), .evt_interval(evt_interval), .fold_en(fold_en),
        .clr_stats(clr_stats), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .drop_cnt(drop_cnt), .oor_cnt(oor_cnt), .fifo_level(fifo_level)
    );

    hist_bin_dispatcher #(.CENTER(200), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .evt_valid(e2_valid), .evt_start(e2_start),
        .evt_end(e2_end), .evt_interval(e2_interval), .fold_en(e2_fold),
        .clr_stats(e2_clr), .mem_req(e2_req), .mem_addr(e2_addr), .mem_ack(e2_ack),
        .hit_cnt(e2_hit), .drop_cnt(e2_drop), .oor_cnt(e2_oor), .fifo_level(e2_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single event, then let it reach the memory port and acknowledge it.
    task automatic send_and_ack(input logic [1:0] s, input logic [1:0] e, input logic [6:0] iv,
                                input logic fold, input logic [7:0] exp_addr, input string tag);
        evt_valid = 1'b1; evt_start = s; evt_end = e; evt_interval = iv; fold_en = fold;
        step();
        evt_valid = 1'b0;
        check({tag, "_req_early"}, {31'd0, mem_req}, 32'd0);
        step();
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, exp_addr});
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        evt_valid = 0; evt_start = 0; evt_end = 0; evt_interval = 0; fold_en = 0;
        clr_stats = 0; mem_ack = 0;
        e2_valid = 0; e2_start = 0; e2_end = 0; e2_interval = 0; e2_fold = 0;
        e2_clr = 0; e2_ack = 0;
        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_hit", {16'd0, hit_cnt}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        check("rst_oor", {16'd0, oor_cnt}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);

        // T1 coincidence -> CENTER
        send_and_ack(2'd0, 2'd3, 7'd0, 1'b0, 8'd128, "t1");
        check("t1_hit", {16'd0, hit_cnt}, 32'd1);

        // T2 positive, negative, folded negative
        send_and_ack(2'd1, 2'd2, 7'd5, 1'b0, 8'd133, "t2_pos");
        send_and_ack(2'd2, 2'd1, 7'd5, 1'b0, 8'd123, "t2_neg");
        send_and_ack(2'd2, 2'd1, 7'd5, 1'b1, 8'd133, "t2_fold");
        check("t2_hit", {16'd0, hit_cnt}, 32'd4);
        check("t2_oor", {16'd0, oor_cnt}, 32'd0);

        // T4 ack held low: six events, bins 129..134
        fold_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            evt_valid = 1'b1; evt_start = 2'd1; evt_end = 2'd2; evt_interval = 7'(i + 1);
            step();
        end
        evt_valid = 1'b0;
        check("t4_level", {29'd0, fifo_level}, 32'd4);
        check("t4_drop", {16'd0, drop_cnt}, 32'd1);
        check("t4_hit", {16'd0, hit_cnt}, 32'd9);
        check("t4_req", {31'd0, mem_req}, 32'd1);
        check("t4_addr0", {24'd0, mem_addr}, 32'd129);
        step();
        check("t4_frozen", {24'd0, mem_addr}, 32'd129);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_b2b_req", {31'd0, mem_req}, 32'd1);
            check("t4_b2b_addr", {24'd0, mem_addr}, 32'(130 + k));
        end
        step();
        check("t4_done_req", {31'd0, mem_req}, 32'd0);
        check("t4_done_level", {29'd0, fifo_level}, 32'd0);
        mem_ack = 1'b0;

        // T5 asynchronous reset with a request outstanding and three bins queued
        for (int i = 0; i < 4; i++) begin
            evt_valid = 1'b1; evt_start = 2'd1; evt_end = 2'd2; evt_interval = 7'(i + 10);
            step();
        end
        evt_valid = 1'b0;
        check("t5_pre_level", {29'd0, fifo_level}, 32'd3);
        check("t5_pre_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_req", {31'd0, mem_req}, 32'd0);
        check("t5_addr", {24'd0, mem_addr}, 32'd0);
        check("t5_level", {29'd0, fifo_level}, 32'd0);
        check("t5_hit", {16'd0, hit_cnt}, 32'd0);
        check("t5_drop", {16'd0, drop_cnt}, 32'd0);
        check("t5_oor", {16'd0, oor_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t5_after_req", {31'd0, mem_req}, 32'd0);
        check("t5_after_level", {29'd0, fifo_level}, 32'd0);

        // T3 on CENTER=200 instance: 200+60 is out of range; coincidence with interval 4 ignored
        e2_valid = 1'b1; e2_start = 2'd1; e2_end = 2'd2; e2_interval = 7'd60;
        step();
        e2_valid = 1'b0;
        check("t3_oor", {30'd0, e2_oor}, 32'd1);
        check("t3_level", {29'd0, e2_level}, 32'd0);
        step();
        check("t3_req", {31'd0, e2_req}, 32'd0);
        e2_valid = 1'b1; e2_start = 2'd0; e2_end = 2'd3; e2_interval = 7'd4;
        step();
        e2_valid = 1'b0;
        step();
        check("t3_ign_hit", {30'd0, e2_hit}, 32'd0);
        check("t3_ign_oor", {30'd0, e2_oor}, 32'd1);
        check("t3_ign_req", {31'd0, e2_req}, 32'd0);

        // T6 saturation with CNT_W=2: nine events, ack low -> 5 hits, 4 drops
        for (int i = 0; i < 9; i++) begin
            e2_valid = 1'b1; e2_start = 2'd1; e2_end = 2'd2; e2_interval = 7'd1;
            step();
        end
        check("t6_drop_sat", {30'd0, e2_drop}, 32'd3);
        check("t6_hit_sat", {30'd0, e2_hit}, 32'd3);
        check("t6_level", {29'd0, e2_level}, 32'd4);
        e2_ack = 1'b1; e2_clr = 1'b1;
        step();
        e2_clr = 1'b0;
        check("t6_clr_hit", {30'd0, e2_hit}, 32'd0);
        check("t6_clr_drop", {30'd0, e2_drop}, 32'd0);
        check("t6_clr_oor", {30'd0, e2_oor}, 32'd0);
        check("t6_clr_level", {29'd0, e2_level}, 32'd4);
        step();
        e2_valid = 1'b0;
        check("t6_hit_after", {30'd0, e2_hit}, 32'd1);
        check("t6_addr", {24'd0, e2_addr}, 32'd201);
        for (int i = 0; i < 6; i++) step();
        check("t6_drain_req", {31'd0, e2_req}, 32'd0);
        e2_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
